// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 32-bit ALU and its arbiter:
//               select codes, arithmetic-class test, FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU select codes
    localparam logic [3:0] ALU_PASS = 4'h0;  // A + Cin
    localparam logic [3:0] ALU_ADD  = 4'h1;  // A + B + Cin
    localparam logic [3:0] ALU_SUBB = 4'h2;  // A + ~B + Cin
    localparam logic [3:0] ALU_DEC  = 4'h3;  // A - 1 + Cin
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_NOT  = 4'h7;
    localparam logic [3:0] ALU_SHR  = 4'h8;  // 4'hA is an alias
    localparam logic [3:0] ALU_SHL  = 4'hC;  // 4'hD is an alias

    // Arbiter FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Carry-out is meaningful only for the arithmetic class
    function automatic logic is_arith(input logic [3:0] sel);
        return (sel[3:2] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_32bit_modular.sv
`default_nettype none
// ============================================================================
// Module      : alu_32bit_modular
// Description : Bit-sliced 32-bit ALU. Ripple-carry adder slices with a
//               per-slice B-operand modifier, bitwise logic, 1-bit shifts.
//               o_cout is the raw adder carry; callers mask it by class.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_32bit_modular
    import alu_pkg::*;
(
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    input  logic        i_dinl,
    input  logic        i_dinr,
    output logic [31:0] o_f,
    output logic        o_cout
);

    logic [31:0] w_bop;
    logic [31:0] w_sum;
    logic        w_carry;
    logic [31:0] w_logic;
    logic [31:0] w_shr;
    logic [31:0] w_shl;

    // B-operand modifier: 0, B, ~B or all-ones (the -1 of the decrement)
    always_comb begin
        w_bop = '0;
        case (i_sel[1:0])
            2'b00:   w_bop = '0;
            2'b01:   w_bop = i_b;
            2'b10:   w_bop = ~i_b;
            default: w_bop = '1;
        endcase
    end

    // Ripple-carry adder, one full-adder slice per bit
    always_comb begin
        logic c;
        c     = i_cin;
        w_sum = '0;
        for (int i = 0; i < 32; i++) begin
            w_sum[i] = i_a[i] ^ w_bop[i] ^ c;
            c        = (i_a[i] & w_bop[i]) | (c & (i_a[i] ^ w_bop[i]));
        end
        w_carry = c;
    end

    // Bitwise logic unit
    always_comb begin
        w_logic = '0;
        case (i_sel[1:0])
            2'b00:   w_logic = i_a & i_b;
            2'b01:   w_logic = i_a | i_b;
            2'b10:   w_logic = i_a ^ i_b;
            default: w_logic = ~i_a;
        endcase
    end

    assign w_shr = {i_dinl, i_a[31:1]};
    assign w_shl = {i_a[30:0], i_dinr};

    // Result select; unassigned codes simply pass A through
    always_comb begin
        o_f = i_a;
        case (i_sel)
            ALU_PASS, ALU_ADD, ALU_SUBB, ALU_DEC: o_f = w_sum;
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOT:    o_f = w_logic;
            ALU_SHR, 4'hA:                        o_f = w_shr;
            ALU_SHL, 4'hD:                        o_f = w_shl;
            default:                              o_f = i_a;
        endcase
    end

    assign o_cout = w_carry;

endmodule
`default_nettype wire

// File: rtl/alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu32_arbiter
// Description : Two-requester round-robin (or fixed-priority) arbiter and
//               IDLE/EXEC/RESP sequencer around one shared 32-bit ALU.
//               One operation in flight; result returned with requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module alu32_arbiter
    import alu_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_sel,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_cin,
    input  logic [1:0]  req_dinl,
    input  logic [1:0]  req_dinr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_f,
    output logic        rsp_cout
);

    logic [1:0]  r_state;
    logic        r_ptr;
    logic [3:0]  r_sel;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_cin;
    logic        r_dinl;
    logic        r_dinr;
    logic        r_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_f;
    logic        r_rsp_cout;

    logic [1:0]  w_grant;
    logic        w_winner;
    logic [31:0] w_alu_f;
    logic        w_alu_cout;

    // One-hot grant in IDLE; suppressed while reset is held so nothing is
    // offered to requesters before the first rising edge after release
    always_comb begin
        w_grant = 2'b00;
        if (rst_n && (r_state == IDLE)) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = (ROUND_ROBIN && r_ptr) ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_winner  = w_grant[1];
    assign req_ready = w_grant;

    // The ALU only ever sees the operand registers
    alu_32bit_modular u_alu (
        .i_sel  (r_sel),
        .i_a    (r_a),
        .i_b    (r_b),
        .i_cin  (r_cin),
        .i_dinl (r_dinl),
        .i_dinr (r_dinr),
        .o_f    (w_alu_f),
        .o_cout (w_alu_cout)
    );

    // Sequencer: capture winner's operands, execute, hold response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_sel       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_dinl      <= 1'b0;
            r_dinr      <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_sel   <= w_winner ? req_sel[7:4]   : req_sel[3:0];
                        r_a     <= w_winner ? req_a[63:32]   : req_a[31:0];
                        r_b     <= w_winner ? req_b[63:32]   : req_b[31:0];
                        r_cin   <= w_winner ? req_cin[1]     : req_cin[0];
                        r_dinl  <= w_winner ? req_dinl[1]    : req_dinl[0];
                        r_dinr  <= w_winner ? req_dinr[1]    : req_dinr[0];
                        r_id    <= w_winner;
                        if (ROUND_ROBIN) begin
                            r_ptr <= ~w_winner;
                        end
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_f     <= w_alu_f;
                    r_rsp_cout  <= w_alu_cout & is_arith(r_sel);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_f     = r_rsp_f;
    assign rsp_cout  = r_rsp_cout;

endmodule
`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu32_arbiter
// Description : Self-checking bench for alu32_arbiter. Directed vector table,
//               round-robin vs fixed priority, backpressure, reset in EXEC,
//               and a randomised run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu32_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [7:0]  req_sel;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_cin;
    logic [1:0]  req_dinl;
    logic [1:0]  req_dinr;
    logic        rsp_ready;

    logic [1:0]  rr_req_ready, fx_req_ready;
    logic        rr_rsp_valid, fx_rsp_valid;
    logic        rr_rsp_id,    fx_rsp_id;
    logic [31:0] rr_rsp_f,     fx_rsp_f;
    logic        rr_rsp_cout,  fx_rsp_cout;

    int n_pass  = 0;
    int n_total = 0;

    alu32_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_req_ready),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_dinl(req_dinl), .req_dinr(req_dinr), .rsp_valid(rr_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id), .rsp_f(rr_rsp_f), .rsp_cout(rr_rsp_cout)
    );

    alu32_arbiter #(.ROUND_ROBIN(1'b0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fx_req_ready),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_dinl(req_dinl), .req_dinr(req_dinr), .rsp_valid(fx_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id), .rsp_f(fx_rsp_f), .rsp_cout(fx_rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        id;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        dinl;
        logic        dinr;
        logic [31:0] f;
        logic        cout;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] f;
        logic        cout;
        logic [3:0]  sel;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_payload(input logic id, input logic [3:0] s, input logic [31:0] a,
                               input logic [31:0] b, input logic cin, input logic dl,
                               input logic dr);
        if (id) begin
            req_sel[7:4] = s;  req_a[63:32] = a; req_b[63:32] = b;
            req_cin[1] = cin;  req_dinl[1] = dl; req_dinr[1] = dr;
        end else begin
            req_sel[3:0] = s;  req_a[31:0] = a;  req_b[31:0] = b;
            req_cin[0] = cin;  req_dinl[0] = dl; req_dinr[0] = dr;
        end
    endtask

    function automatic logic [1:0] arb(input logic [1:0] v, input logic p);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return p ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic alu_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic dl, input logic dr,
                             output logic [31:0] f, output logic co);
        logic [32:0] t;
        t  = '0;
        f  = a;
        co = 1'b0;
        case (s)
            4'h0: t = {1'b0, a} + {32'b0, cin};
            4'h1: t = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            4'h2: t = {1'b0, a} + {1'b0, ~b} + {32'b0, cin};
            4'h3: t = {1'b0, a} + 33'h0FFFFFFFF + {32'b0, cin};
            4'h4: f = a & b;
            4'h5: f = a | b;
            4'h6: f = a ^ b;
            4'h7: f = ~a;
            4'h8, 4'hA: f = {dl, a[31:1]};
            4'hC, 4'hD: f = {a[30:0], dr};
            default: f = a;
        endcase
        if (s[3:2] == 2'b00) begin
            f  = t[31:0];
            co = t[32];
        end
    endtask

    // Single request from one requester with rsp_ready high; enters and
    // leaves 1 time unit after a rising edge with the FSM in IDLE
    task automatic run_vec(input vec_t v);
        int cnt;
        set_payload(v.id, v.sel, v.a, v.b, v.cin, v.dinl, v.dinr);
        req_valid = 2'b00;
        req_valid[v.id] = 1'b1;
        rsp_ready = 1'b1;
        #1;
        cnt = 0;
        while (rr_req_ready[v.id] !== 1'b1 && cnt < 20) begin
            @(posedge clk); #2;
            cnt++;
        end
        chk("vec_grant", {30'b0, rr_req_ready}, (v.id ? 32'd2 : 32'd1));
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("vec_exec_no_rsp", {31'b0, rr_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("vec_rsp_valid", {31'b0, rr_rsp_valid}, 32'd1);
        chk("vec_f", rr_rsp_f, v.f);
        chk("vec_cout", {31'b0, rr_rsp_cout}, {31'b0, v.cout});
        chk("vec_id", {31'b0, rr_rsp_id}, {31'b0, v.id});
        @(posedge clk); #1;
        chk("vec_accepted", {31'b0, rr_rsp_valid}, 32'd0);
    endtask

    vec_t vecs[15];
    logic [3:0] codes[12];
    exp_t sb[$];

    initial begin
        int cnt;
        vecs[0]  = '{1'b1, 4'h1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[1]  = '{1'b0, 4'h4, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 4'h2, 32'h00000004, 32'h00000003, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b1};
        vecs[3]  = '{1'b1, 4'h0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b0, 4'h3, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{1'b1, 4'h3, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000004, 1'b1};
        vecs[6]  = '{1'b0, 4'h5, 32'h0F0F0000, 32'h000000F0, 1'b0, 1'b0, 1'b0, 32'h0F0F00F0, 1'b0};
        vecs[7]  = '{1'b1, 4'h6, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 32'hF0F00F0F, 1'b0};
        vecs[8]  = '{1'b0, 4'h7, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'hEDCBA987, 1'b0};
        vecs[9]  = '{1'b1, 4'h8, 32'h80000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'hC0000000, 1'b0};
        vecs[10] = '{1'b0, 4'hA, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0};
        vecs[11] = '{1'b1, 4'hD, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 4'hC, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h2468ACF1, 1'b0};
        vecs[13] = '{1'b1, 4'h1, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h80000001, 1'b0};
        vecs[14] = '{1'b0, 4'h2, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0};
        codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hD};

        // ---------------- reset state ----------------
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req_sel = '0; req_a = '0; req_b = '0; req_cin = '0; req_dinl = '0; req_dinr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {30'b0, rr_req_ready}, 32'd0);
        chk("rst_req_ready_fx", {30'b0, fx_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rr_rsp_valid}, 32'd0);
        chk("rst_rsp_f", rr_rsp_f, 32'd0);
        chk("rst_rsp_cout", {31'b0, rr_rsp_cout}, 32'd0);
        chk("rst_rsp_id", {31'b0, rr_rsp_id}, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // ---------------- round robin vs fixed priority ----------------
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        set_payload(1'b0, 4'h4, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
        set_payload(1'b1, 4'h1, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0);
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            cnt = 0;
            while (rr_req_ready == 2'b00 && cnt < 20) begin
                @(posedge clk); #2;
                cnt++;
            end
            chk("rr_throughput_wait", cnt, 32'd0);
            chk("rr_order", {30'b0, rr_req_ready}, ((k % 2) != 0) ? 32'd2 : 32'd1);
            chk("fixed_prio", {30'b0, fx_req_ready}, 32'd1);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("rr_rsp_id", {31'b0, rr_rsp_id}, ((k % 2) != 0) ? 32'd1 : 32'd0);
            chk("rr_rsp_f", rr_rsp_f, ((k % 2) != 0) ? 32'd3 : 32'd0);
            chk("rr_rsp_cout", {31'b0, rr_rsp_cout}, 32'd0);
            chk("fx_rsp_id", {31'b0, fx_rsp_id}, 32'd0);
            chk("fx_rsp_f", fx_rsp_f, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;

        // ---------------- backpressure ----------------
        set_payload(1'b0, 4'hC, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1);
        req_valid = 2'b01; rsp_ready = 1'b0;
        #1;
        chk("bp_grant", {30'b0, rr_req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid_held", {31'b0, rr_rsp_valid}, 32'd1);
            chk("bp_f_held", rr_rsp_f, 32'h2468ACF1);
            chk("bp_id_held", {31'b0, rr_rsp_id}, 32'd0);
            chk("bp_no_grant", {30'b0, rr_req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_cout", {31'b0, rr_rsp_cout}, 32'd0);
        chk("bp_still_valid", {31'b0, rr_rsp_valid}, 32'd1);
        rsp_ready = 1'b1; req_valid = 2'b00;
        @(posedge clk); #1;
        chk("bp_accepted", {31'b0, rr_rsp_valid}, 32'd0);

        // ---------------- reset during EXEC ----------------
        set_payload(1'b0, 4'h1, 32'h00000005, 32'h00000006, 1'b0, 1'b0, 1'b0);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1; rst_n = 1'b0; #1;
        chk("rst_exec_valid", {31'b0, rr_rsp_valid}, 32'd0);
        chk("rst_exec_ready", {30'b0, rr_req_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_exec_no_rsp", {31'b0, rr_rsp_valid}, 32'd0);
        set_payload(1'b0, 4'h2, 32'h00000004, 32'h00000003, 1'b1, 1'b0, 1'b0);
        set_payload(1'b1, 4'h1, 32'h00000009, 32'h00000009, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_ptr_zero", {30'b0, rr_req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("post_rst_exec", {31'b0, rr_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", {31'b0, rr_rsp_valid}, 32'd1);
        chk("post_rst_f", rr_rsp_f, 32'h00000001);
        chk("post_rst_cout", {31'b0, rr_rsp_cout}, 32'd1);
        chk("post_rst_id", {31'b0, rr_rsp_id}, 32'd0);
        @(posedge clk); #1;

        // ---------------- random traffic vs model ----------------
        begin
            int ops;
            int cyc;
            int m_state;
            logic m_ptr;
            logic [1:0] hs;
            logic [1:0] exp_ready;
            exp_t e;
            logic [31:0] mf;
            logic mc;
            rst_n = 1'b0; req_valid = 2'b00; #2; rst_n = 1'b1;
            @(posedge clk); #1;
            ops = 0; cyc = 0; m_state = 0; m_ptr = 1'b0; hs = 2'b00;
            while (ops < 200 && cyc < 6000) begin
                for (int i = 0; i < 2; i++) begin
                    if (hs[i] || !req_valid[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            set_payload(i[0], codes[$urandom_range(0, 11)], $urandom, $urandom,
                                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                        1'($urandom_range(0, 1)));
                            req_valid[i] = 1'b1;
                        end else begin
                            req_valid[i] = 1'b0;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
                rsp_ready = ($urandom_range(0, 3) != 0);
                #1;
                exp_ready = (m_state == 0) ? arb(req_valid, m_ptr) : 2'b00;
                chk("rnd_ready", {30'b0, rr_req_ready}, {30'b0, exp_ready});
                chk("rnd_rsp_valid", {31'b0, rr_rsp_valid}, (m_state == 2) ? 32'd1 : 32'd0);
                hs = req_valid & exp_ready;
                case (m_state)
                    0: if (hs != 2'b00) begin
                        e.id = hs[1];
                        e.sel = hs[1] ? req_sel[7:4] : req_sel[3:0];
                        alu_model(e.sel, hs[1] ? req_a[63:32] : req_a[31:0],
                                  hs[1] ? req_b[63:32] : req_b[31:0],
                                  req_cin[hs[1]], req_dinl[hs[1]], req_dinr[hs[1]], mf, mc);
                        e.f = mf; e.cout = mc;
                        sb.push_back(e);
                        m_ptr = ~hs[1];
                        m_state = 1;
                    end
                    1: m_state = 2;
                    default: if (rsp_ready) begin
                        if (sb.size() == 0) begin
                            chk("rnd_sb_empty", 32'd0, 32'd1);
                        end else begin
                            e = sb.pop_front();
                            chk("rnd_f", rr_rsp_f, e.f);
                            chk("rnd_id", {31'b0, rr_rsp_id}, {31'b0, e.id});
                            if (e.sel[3:2] == 2'b00)
                                chk("rnd_cout", {31'b0, rr_rsp_cout}, {31'b0, e.cout});
                        end
                        ops++;
                        m_state = 0;
                    end
                endcase
                @(posedge clk); #1;
                cyc++;
            end
            chk("rnd_ops_done", ops, 32'd200);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
